fu_result_buffer: RTL and testbench
===================================

# fu_result_buffer

Parametrised result buffer between a functional unit and its shared result bus (CDB for the ALU, address bus for the memory-address FU). Holds DEPTH completed results tagged with their ROB index. Drives one entry onto the bus whenever the bus arbiter grants access. Adds three things to the fixed 4-entry buffer:
- a valid/ready backpressure handshake toward the FU;
- misspeculation flush by ROB age;
- a compile-time oldest-first issue mode.

## Interface
- XLEN, 32, data width
- DEPTH, 4, entry count; power of two, ≥2
- ROB_SIZE, 16, ROB entry count; ≤ 2**ROB_TAG_WIDTH
- ROB_TAG_WIDTH, 4, ROB tag width
- clk  in  1  clock; everything on posedge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  FU presents a result
- in_ready  out  1  buffer accepts; equals !full
- in_value  in  XLEN  result data
- in_tag  in  ROB_TAG_WIDTH  ROB index of result
- in_exception  in  1  result raised an exception
- in_redirect_mispredicted  in  1  redirect FU mispredict flag; tie 0 on other FUs
- rob_head  in  ROB_TAG_WIDTH  current ROB head (oldest instruction)
- flush  in  1  flush everything at or younger than flush_tag
- flush_tag  in  ROB_TAG_WIDTH  first ROB index to flush
- bus_permit  in  1  arbiter grant for this cycle
- bus_data  out  XLEN  selected value; Z when !bus_permit
- bus_tag  out  ROB_TAG_WIDTH  selected tag; Z when !bus_permit
- bus_exception  out  1  selected flag; Z when !bus_permit
- bus_redirect_mispredicted  out  1  selected flag; Z when !bus_permit
- not_empty  out  1  request to arbiter
- full  out  1  all entries valid
- count  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- Per entry: value, tag, exception, redirect_mispredicted, valid. Plus a last_idx register ($clog2(DEPTH) bits).
- Age of a tag:
  - age(t) = t − rob_head when t ≥ rob_head;
  - otherwise age(t) = t + ROB_SIZE − rob_head.
  - Compute in ROB_TAG_WIDTH+1 bits.
- Kill condition: kill(t) = flush && age(t) ≥ age(flush_tag).
- Live entries: live[i] = valid[i] && !kill(tag[i]).
  - not_empty = |live.
  - Selection uses live only, so a killed entry is never driven onto the bus.
- Accept: in_valid && in_ready. Write goes to the lowest-index invalid entry.
  - If kill(in_tag) holds in the same cycle, the write is dropped. The entry stays invalid, but the handshake still completes.
- Selection, default mode: round-robin. Take the first live index searching last_idx+1, last_idx+2, … with wrap modulo DEPTH.
- Broadcast cycle (bus_permit && not_empty):
  - bus outputs carry entry sel;
  - on the next edge valid[sel] ← 0 and last_idx ← sel.
- bus_permit with !not_empty is an arbiter error.
  - Outputs still drive entry sel (don't-care data).
  - No state changes.
- Flush cycle: every valid entry with kill=1 is cleared on the edge.
- count and full are registered-state derived (sum/AND of valid). They do not reflect the same-cycle flush.

## Timing
- Reset (reset=1 at an edge):
  - all valid ← 0, last_idx ← DEPTH−1;
  - from the next cycle: in_ready=1, not_empty=0, full=0, count=0, bus outputs Z.
  - Payload registers are not reset.
- Reset wins over any same-cycle write, broadcast or flush.
- Write latency: result accepted at edge N is visible (not_empty, broadcastable) in cycle N+1. There is no same-cycle bypass.
- Bus outputs are combinational from bus_permit, flush, flush_tag and rob_head. The arbiter grants in the same cycle as not_empty.
- Broadcast and write in the same cycle are legal.
  - in_ready is based on pre-edge full, so a full buffer never accepts, even while broadcasting.
  - The write slot is chosen from pre-edge valid, so it never collides with sel.
- Broadcast, write and flush may all coincide. Apply in this order:
  1. kill mask;
  2. sel among live entries;
  3. write (if not killed);
  4. clear.
- Age wrap: rob_head=14, ROB_SIZE=16 → tag 1 has age 3, tag 13 has age 15.

## Configuration
- FU_BUF_OLDEST_FIRST_EN defined: sel is the live entry with minimum age(tag), ties to lower index. last_idx is still updated but unused.
- Undefined: round-robin as above.
- Ports and all other behaviour are identical in both builds.

## Test plan
- Reset, then write tags 3, 4, 5 with no permit → count=3, not_empty=1, in_ready=1. Grant 3 cycles → bus_tag 3, 4, 5 in order (entries 0, 1, 2). Then count=0.
- Fill DEPTH=4 entries → full=1, in_ready=0. Hold in_valid with tag 9 under permit → tag 9 not accepted until the cycle after full drops.
- rob_head=14, entries tags 15, 0, 2, 13, flush_tag=0, flush=1 → tags 0 and 2 cleared, and 13 (age 15) cleared. Tag 15 survives: count=1 next cycle.
- Flush with flush_tag=5, rob_head=0, simultaneous write tag 7 and permit with the only live candidate tag 6 → tag 6 not driven, not_empty=0 that cycle, write of 7 dropped, count=0.
- Round-robin: entries tags 1, 2, last_idx=0, write tag 3 into freed entry 0 during the broadcast of entry 1 → next grants yield entry 2, then entry 0.
- FU_BUF_OLDEST_FIRST_EN, rob_head=8, entries tags 10, 9, 3 → grants yield 9, 10, 3.

Source files
------------

// File: rtl/fu_result_buffer.sv
// ============================================================================
// fu_result_buffer
// ----------------------------------------------------------------------------
// Result buffer that sits between a functional unit and its shared result bus.
// It holds up to DEPTH completed results, each tagged with its ROB index.
// When the bus arbiter grants the bus, one live entry is driven onto it.
// It also supports:
//   - a valid/ready handshake toward the FU (in_ready = !full);
//   - misspeculation flush of every entry at or younger than flush_tag,
//     where age is measured relative to rob_head;
//   - optional oldest-first selection, enabled by the compile-time macro
//     FU_BUF_OLDEST_FIRST_EN. With the macro undefined, selection is
//     round-robin starting after the last broadcast index.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid/in_ready           FU handshake
//   in_value/in_tag             result data and its ROB index
//   in_exception                exception flag that travels with the result
//   in_redirect_mispredicted    mispredict flag that travels with the result
//   rob_head                    oldest ROB index (age reference)
//   flush/flush_tag             kill every entry with age >= age(flush_tag)
//   bus_permit                  arbiter grant; bus outputs are Z without it
//   bus_data/bus_tag/
//   bus_exception/
//   bus_redirect_mispredicted   selected entry payload
//   not_empty                   request to the arbiter (any live entry)
//   full                        all entries valid
//   count                       number of valid entries
// ============================================================================
module fu_result_buffer #(
    parameter int XLEN          = 32,
    parameter int DEPTH         = 4,
    parameter int ROB_SIZE      = 16,
    parameter int ROB_TAG_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_value,
    input  logic [ROB_TAG_WIDTH-1:0]   in_tag,
    input  logic                       in_exception,
    input  logic                       in_redirect_mispredicted,
    input  logic [ROB_TAG_WIDTH-1:0]   rob_head,
    input  logic                       flush,
    input  logic [ROB_TAG_WIDTH-1:0]   flush_tag,
    input  logic                       bus_permit,
    output logic [XLEN-1:0]            bus_data,
    output logic [ROB_TAG_WIDTH-1:0]   bus_tag,
    output logic                       bus_exception,
    output logic                       bus_redirect_mispredicted,
    output logic                       not_empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int AGE_W = ROB_TAG_WIDTH + 1;

    // Distance of tag t from the ROB head, with wrap at ROB_SIZE.
    function automatic logic [AGE_W-1:0] f_age(
        input logic [ROB_TAG_WIDTH-1:0] t,
        input logic [ROB_TAG_WIDTH-1:0] h
    );
        logic [AGE_W-1:0] a;
        if (t >= h) begin
            a = {1'b0, t} - {1'b0, h};
        end else begin
            a = {1'b0, t} + AGE_W'(ROB_SIZE) - {1'b0, h};
        end
        return a;
    endfunction

    logic [XLEN-1:0]          r_value [DEPTH];
    logic [ROB_TAG_WIDTH-1:0] r_tag   [DEPTH];
    logic                     r_exc   [DEPTH];
    logic                     r_red   [DEPTH];
    logic [DEPTH-1:0]         r_valid;
    logic [IDX_W-1:0]         r_last_idx;

    logic [AGE_W-1:0]         w_age [DEPTH];
    logic [AGE_W-1:0]         w_flush_age;
    logic [DEPTH-1:0]         w_kill;
    logic [DEPTH-1:0]         w_live;
    logic                     w_in_kill;
    logic [IDX_W-1:0]         w_sel;
    logic [IDX_W-1:0]         w_wr_idx;
    logic                     w_bcast;
    logic                     w_wr_en;
    logic [CNT_W-1:0]         w_count;
    logic [DEPTH-1:0]         w_valid_nxt;

    // Entry ages, kill mask and live mask for the current cycle.
    always_comb begin
        w_flush_age = f_age(flush_tag, rob_head);
        w_in_kill   = flush && (f_age(in_tag, rob_head) >= w_flush_age);
        for (int i = 0; i < DEPTH; i++) begin
            w_age[i]  = f_age(r_tag[i], rob_head);
            w_kill[i] = flush && (w_age[i] >= w_flush_age);
            w_live[i] = r_valid[i] && !w_kill[i];
        end
    end

`ifdef FU_BUF_OLDEST_FIRST_EN
    // Oldest live entry wins; scanning downward with <= lets the lower index win ties.
    always_comb begin
        logic [AGE_W-1:0] w_best;
        logic             w_pick;
        w_sel  = r_last_idx + IDX_W'(1);
        w_best = {AGE_W{1'b1}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_pick = w_live[i] && (w_age[i] <= w_best);
            w_sel  = w_pick ? IDX_W'(i) : w_sel;
            w_best = w_pick ? w_age[i] : w_best;
        end
    end
`else
    // Round-robin: first live index after r_last_idx. Scanning the offsets
    // downward leaves the nearest live one in w_sel; offset DEPTH wraps to
    // r_last_idx itself, which is therefore checked last.
    always_comb begin
        logic [IDX_W-1:0] w_idx;
        w_sel = r_last_idx + IDX_W'(1);
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = r_last_idx + IDX_W'(k);
            w_sel = w_live[w_idx] ? w_idx : w_sel;
        end
    end
`endif

    // Lowest-index free slot and the valid count, both from pre-edge state.
    always_comb begin
        w_wr_idx = {IDX_W{1'b0}};
        w_count  = {CNT_W{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_wr_idx = !r_valid[i] ? IDX_W'(i) : w_wr_idx;
            w_count  = w_count + CNT_W'(r_valid[i]);
        end
    end

    assign full      = &r_valid;
    assign in_ready  = !full;
    assign count     = w_count;
    assign not_empty = |w_live;
    assign w_bcast   = bus_permit && not_empty;
    // A killed incoming result still completes the handshake but is not stored.
    assign w_wr_en   = in_valid && in_ready && !w_in_kill;

    // Next valid mask: flush clear, broadcast clear, then the write. The write
    // slot is free pre-edge, so it never collides with the selected entry.
    always_comb begin
        w_valid_nxt = r_valid & ~w_kill;
        w_valid_nxt = w_valid_nxt & ~(w_bcast ? ({{(DEPTH-1){1'b0}}, 1'b1} << w_sel)
                                              : {DEPTH{1'b0}});
        w_valid_nxt = w_valid_nxt | (w_wr_en ? ({{(DEPTH-1){1'b0}}, 1'b1} << w_wr_idx)
                                             : {DEPTH{1'b0}});
    end

    // Control state: valid bits and the last broadcast index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= {DEPTH{1'b0}};
            r_last_idx <= IDX_W'(DEPTH - 1);
        end else begin
            r_valid <= w_valid_nxt;
            if (w_bcast) begin
                r_last_idx <= w_sel;
            end
        end
    end

    // Payload storage; not reset because valid gates every use of it.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_value[w_wr_idx] <= in_value;
            r_tag[w_wr_idx]   <= in_tag;
            r_exc[w_wr_idx]   <= in_exception;
            r_red[w_wr_idx]   <= in_redirect_mispredicted;
        end
    end

    assign bus_data                  = bus_permit ? r_value[w_sel] : {XLEN{1'bz}};
    assign bus_tag                   = bus_permit ? r_tag[w_sel]   : {ROB_TAG_WIDTH{1'bz}};
    assign bus_exception             = bus_permit ? r_exc[w_sel]   : 1'bz;
    assign bus_redirect_mispredicted = bus_permit ? r_red[w_sel]   : 1'bz;

endmodule

// File: tb/tb_fu_result_buffer.sv
module tb_fu_result_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int RS    = 16;
    localparam int TW    = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_value;
    logic [TW-1:0]   in_tag;
    logic            in_exception;
    logic            in_redirect_mispredicted;
    logic [TW-1:0]   rob_head;
    logic            flush;
    logic [TW-1:0]   flush_tag;
    logic            bus_permit;
    logic [XLEN-1:0] bus_data;
    logic [TW-1:0]   bus_tag;
    logic            bus_exception;
    logic            bus_redirect_mispredicted;
    logic            not_empty;
    logic            full;
    logic [2:0]      count;

    fu_result_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .ROB_SIZE(RS), .ROB_TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_tag(in_tag),
        .in_exception(in_exception), .in_redirect_mispredicted(in_redirect_mispredicted),
        .rob_head(rob_head), .flush(flush), .flush_tag(flush_tag), .bus_permit(bus_permit),
        .bus_data(bus_data), .bus_tag(bus_tag), .bus_exception(bus_exception),
        .bus_redirect_mispredicted(bus_redirect_mispredicted),
        .not_empty(not_empty), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: a small table of slots.
    bit              m_v   [DEPTH];
    int              m_tag [DEPTH];
    logic [XLEN-1:0] m_val [DEPTH];
    bit              m_exc [DEPTH];
    bit              m_red [DEPTH];
    int              m_last;
    int              rob_h;

    int n_cmp = 0;
    int n_err = 0;
    int last_bus_tag;
    bit last_ne;

    function automatic int age(input int t);
        return (t - rob_h + RS) % RS;
    endfunction

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; bus_permit = 1'b0; flush = 1'b0;
        in_tag = '0; flush_tag = '0; in_value = '0; in_exception = 1'b0;
        in_redirect_mispredicted = 1'b0; rob_head = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
        m_last = DEPTH - 1;
    endtask

    // One clock cycle: drive, check outputs against the model, advance model.
    task automatic cyc(input bit v, input int tag, input bit perm, input bit fl, input int ftag);
        bit kill [DEPTH];
        bit live [DEPTH];
        bit ne, found, acc, in_kill;
        int cnt, sel, wr;
        in_valid = v; in_tag = TW'(tag); in_value = $urandom;
        in_exception = 1'($urandom_range(0, 1));
        in_redirect_mispredicted = 1'($urandom_range(0, 1));
        rob_head = TW'(rob_h); bus_permit = perm; flush = fl; flush_tag = TW'(ftag);
        #2;
        ne = 0; cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = fl && (age(m_tag[i]) >= age(ftag));
            live[i] = m_v[i] && !kill[i];
            ne = ne | live[i];
            cnt += m_v[i];
        end
        found = 0; sel = 0;
`ifdef FU_BUF_OLDEST_FIRST_EN
        for (int i = 0; i < DEPTH; i++)
            if (live[i] && (!found || age(m_tag[i]) < age(m_tag[sel]))) begin
                sel = i; found = 1;
            end
`else
        for (int k = 1; k <= DEPTH; k++)
            if (!found && live[(m_last + k) % DEPTH]) begin
                sel = (m_last + k) % DEPTH; found = 1;
            end
`endif
        chk("count", 32'(count), 32'(cnt));
        chk("full", 32'(full), 32'(cnt == DEPTH));
        chk("in_ready", 32'(in_ready), 32'(cnt != DEPTH));
        chk("not_empty", 32'(not_empty), 32'(ne));
        last_ne = not_empty;
        last_bus_tag = -1;
        if (perm && ne) begin
            chk("bus_tag", 32'(bus_tag), 32'(m_tag[sel]));
            chk("bus_data", bus_data, m_val[sel]);
            chk("bus_exc", 32'(bus_exception), 32'(m_exc[sel]));
            chk("bus_red", 32'(bus_redirect_mispredicted), 32'(m_red[sel]));
            last_bus_tag = int'(bus_tag);
        end
        // model update
        acc = v && (cnt != DEPTH);
        in_kill = fl && (age(tag) >= age(ftag));
        wr = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) wr = i;
        for (int i = 0; i < DEPTH; i++) if (kill[i]) m_v[i] = 0;
        if (perm && ne) begin m_v[sel] = 0; m_last = sel; end
        if (acc && !in_kill && wr >= 0) begin
            m_v[wr] = 1; m_tag[wr] = tag; m_val[wr] = in_value;
            m_exc[wr] = in_exception; m_red[wr] = in_redirect_mispredicted;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ne", 32'(not_empty), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_full", 32'(full), 32'd0);

        // Writes then three grants in order
        rob_h = 0;
        cyc(1, 3, 0, 0, 0); cyc(1, 4, 0, 0, 0); cyc(1, 5, 0, 0, 0);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_ne", 32'(not_empty), 32'd1);
        chk("t1_ready", 32'(in_ready), 32'd1);
        cyc(0, 0, 1, 0, 0); chk("t1_g0", 32'(last_bus_tag), 32'd3);
        cyc(0, 0, 1, 0, 0); chk("t1_g1", 32'(last_bus_tag), 32'd4);
        cyc(0, 0, 1, 0, 0); chk("t1_g2", 32'(last_bus_tag), 32'd5);
        chk("t1_empty", 32'(count), 32'd0);

        // Full buffer refuses tag 9 even while broadcasting
        cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 2, 0, 0, 0); cyc(1, 3, 0, 0, 0);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_rdy0", 32'(in_ready), 32'd0);
        cyc(1, 9, 1, 0, 0);
        chk("t2_cnt3", 32'(count), 32'd3);
        chk("t2_rdy1", 32'(in_ready), 32'd1);
        cyc(1, 9, 0, 0, 0);
        chk("t2_cnt4", 32'(count), 32'd4);
        repeat (4) cyc(0, 0, 1, 0, 0);
        chk("t2_drain", 32'(count), 32'd0);

        // Age wrap flush
        do_reset();
        rob_h = 14;
        cyc(1, 15, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 2, 0, 0, 0); cyc(1, 13, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("t3_ne", 32'(last_ne), 32'd1);
        chk("t3_count", 32'(count), 32'd1);

        // Flush kills the only candidate and the incoming write
        do_reset();
        rob_h = 0;
        cyc(1, 6, 0, 0, 0);
        cyc(1, 7, 1, 1, 5);
        chk("t4_ne", 32'(last_ne), 32'd0);
        chk("t4_count", 32'(count), 32'd0);

        // Round-robin around a refilled slot
        do_reset();
        cyc(1, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 2, 0, 0, 0);
        cyc(0, 0, 1, 0, 0); chk("t5_g0", 32'(last_bus_tag), 32'd0);
        cyc(1, 3, 1, 0, 0); chk("t5_g1", 32'(last_bus_tag), 32'd1);
        cyc(0, 0, 1, 0, 0); chk("t5_g2", 32'(last_bus_tag), 32'd2);
        cyc(0, 0, 1, 0, 0); chk("t5_g3", 32'(last_bus_tag), 32'd3);

`ifdef FU_BUF_OLDEST_FIRST_EN
        // Oldest-first with wrapped head
        do_reset();
        rob_h = 8;
        cyc(1, 10, 0, 0, 0); cyc(1, 9, 0, 0, 0); cyc(1, 3, 0, 0, 0);
        cyc(0, 0, 1, 0, 0); chk("t6_g0", 32'(last_bus_tag), 32'd9);
        cyc(0, 0, 1, 0, 0); chk("t6_g1", 32'(last_bus_tag), 32'd10);
        cyc(0, 0, 1, 0, 0); chk("t6_g2", 32'(last_bus_tag), 32'd3);
`endif

        // Randomized traffic against the model
        do_reset();
        rob_h = 0;
        for (int n = 0; n < 600; n++) begin
            if (n % 40 == 0) rob_h = $urandom_range(0, RS - 1);
            cyc($urandom_range(0, 99) < 60, $urandom_range(0, RS - 1),
                $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 8,
                $urandom_range(0, RS - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
